// File: rtl/systolic_input_skew.sv
// systolic_input_skew: FIFO-buffered west-edge feeder for the systolic array.
// Lane i of each popped row vector is delayed i cycles to form the diagonal wavefront.
//  clk, rst        : clock, synchronous active-low reset
//  in_data/valid/ready : row vector push handshake into the FIFO
//  start, row_count    : launch a stream of row_count vectors
//  busy, done          : stream in progress / last element left lane N-1
//  out_data, out_valid : skewed lanes to the array (out_valid[0] is sys_start)
//  fifo_count          : FIFO occupancy
module systolic_input_skew #(
  parameter int SYSTOLIC_ARRAY_WIDTH = 2,
  parameter int DATA_WIDTH           = 16,
  parameter int FIFO_DEPTH           = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic [SYSTOLIC_ARRAY_WIDTH*DATA_WIDTH-1:0] in_data,
  input  logic in_valid,
  output logic in_ready,
  input  logic start,
  input  logic [15:0] row_count,
  output logic busy,
  output logic done,
  output logic [SYSTOLIC_ARRAY_WIDTH*DATA_WIDTH-1:0] out_data,
  output logic [SYSTOLIC_ARRAY_WIDTH-1:0] out_valid,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int N   = SYSTOLIC_ARRAY_WIDTH;
  localparam int DW  = DATA_WIDTH;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int DCW = (N > 1) ? $clog2(N) : 1;

  localparam logic [CW-1:0]  DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [DCW-1:0] DRAIN_C = DCW'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DRAIN
  } state_e;

  state_e state_q, state_d;

  logic [N*DW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [N*DW-1:0] rd_vec;
  logic [15:0]     rows_left;
  logic [DCW-1:0]  drain_cnt;

  logic push, pop, start_ok, last_pop;

  assign in_ready   = count < DEPTH_C;
  assign push       = in_valid & in_ready;
  assign pop        = (state_q == ST_STREAM) & (count != '0);
  assign start_ok   = (state_q == ST_IDLE) & start;
  assign last_pop   = pop & (rows_left == 16'd1);
  assign rd_vec     = mem[rd_ptr];
  assign fifo_count = count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (state_q == ST_IDLE): begin
        if (start)
          state_d = (row_count == '0) ? ST_DRAIN
                                      : ST_STREAM;
      end
      (state_q == ST_STREAM): begin
        if (last_pop) state_d = ST_DRAIN;
      end
      (state_q == ST_DRAIN): begin
        if (drain_cnt == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != ST_IDLE);
    done = (state_q == ST_DRAIN) && (drain_cnt == '0);
  end

  // Drain counts the N-1 extra cycles the last row spends in the skew chain.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rows_left <= '0;
      drain_cnt <= '0;
    end else begin
      if (start_ok) begin
        rows_left <= row_count;
        drain_cnt <= '0;
      end else if (pop) begin
        rows_left <= rows_left - 16'd1;
        if (last_pop) drain_cnt <= DRAIN_C;
      end else if (state_q == ST_DRAIN && drain_cnt != '0) begin
        drain_cnt <= drain_cnt - DCW'(1);
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DW-1:0] d_q [i+1];
    logic [i:0]    v_q;

    always_ff @(posedge clk) begin
      if (!rst) begin
        v_q <= '0;
        for (int k = 0; k <= i; k++) d_q[k] <= '0;
      end else begin
        v_q[0] <= pop;
        d_q[0] <= pop ? rd_vec[i*DW +: DW] : '0;
        for (int k = 1; k <= i; k++) begin
          v_q[k] <= v_q[k-1];
          d_q[k] <= d_q[k-1];
        end
      end
    end

    assign out_data[i*DW +: DW] = d_q[i];
    assign out_valid[i]         = v_q[i];
  end

endmodule

// File: tb/tb_systolic_input_skew.sv
// tb_systolic_input_skew: scenario tasks plus a lane scoreboard
// fed from accepted pushes and drained by out_valid beats.
module tb_systolic_input_skew;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        start = 1'b0;
  logic [15:0] row_count = '0;
  logic        busy;
  logic        done;
  logic [31:0] out_data;
  logic [1:0]  out_valid;
  logic [3:0]  fifo_count;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  logic [15:0] sb0[$];
  logic [15:0] sb1[$];

  systolic_input_skew #(
    .SYSTOLIC_ARRAY_WIDTH(2),
    .DATA_WIDTH(16),
    .FIFO_DEPTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .start(start),
    .row_count(row_count),
    .busy(busy),
    .done(done),
    .out_data(out_data),
    .out_valid(out_valid),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Output beats pop the scoreboard; accepted pushes feed it.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [15:0] e;
      checks++;
      if (out_valid[0] === 1'b1) begin
        if (sb0.size() == 0) begin
          errors++;
          $display("FAIL lane0 got %h with nothing expected",
                   out_data[15:0]);
        end else begin
          e = sb0.pop_front();
          if (out_data[15:0] !== e) begin
            errors++;
            $display("FAIL lane0 data got %h want %h",
                     out_data[15:0], e);
          end
        end
      end else if (out_data[15:0] !== 16'h0) begin
        errors++;
        $display("FAIL lane0 idle got %h want 0000",
                 out_data[15:0]);
      end
      checks++;
      if (out_valid[1] === 1'b1) begin
        if (sb1.size() == 0) begin
          errors++;
          $display("FAIL lane1 got %h with nothing expected",
                   out_data[31:16]);
        end else begin
          e = sb1.pop_front();
          if (out_data[31:16] !== e) begin
            errors++;
            $display("FAIL lane1 data got %h want %h",
                     out_data[31:16], e);
          end
        end
      end else if (out_data[31:16] !== 16'h0) begin
        errors++;
        $display("FAIL lane1 idle got %h want 0000",
                 out_data[31:16]);
      end
      if (rst && in_valid && in_ready) begin
        sb0.push_back(in_data[15:0]);
        sb1.push_back(in_data[31:16]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) step();
    @(negedge clk);
    checks++;
    if ({out_valid, busy, done, out_data} !== '0) begin
      errors++;
      $display("FAIL rst_out got v=%b b=%b d=%b data=%h want 0",
               out_valid, busy, done, out_data);
    end
    checks++;
    if (fifo_count !== 4'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_fifo got cnt=%0d rdy=%b want 0/1",
               fifo_count, in_ready);
    end
    step();
    rst = 1'b1;
    mon_en = 1'b1;
    in_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      in_data = {16'(16'h0a10 + j), 16'(16'h0a00 + j)};
      step();
    end
    in_valid = 1'b0;
    start = 1'b1;
    row_count = 16'd3;
    step();
    start = 1'b0;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 2'b11) begin
      errors++;
      $display("FAIL rst_mid_pre got v=%b want 11", out_valid);
    end
    step();
    rst = 1'b1;
    sb0.delete();
    sb1.delete();
    @(negedge clk);
    checks++;
    if ({out_valid, busy, done, out_data} !== '0) begin
      errors++;
      $display("FAIL rst_mid_out got v=%b b=%b d=%b data=%h want 0",
               out_valid, busy, done, out_data);
    end
    checks++;
    if (fifo_count !== 4'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_fifo got cnt=%0d rdy=%b want 0/1",
               fifo_count, in_ready);
    end
    step();
  endtask

  task automatic test_basic();
    logic [3:0] e;
    in_valid = 1'b1;
    in_data = {16'h0002, 16'h0001};
    step();
    in_data = {16'h0004, 16'h0003};
    step();
    in_valid = 1'b0;
    start = 1'b1;
    row_count = 16'd2;
    step();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      e = {k <= 3, k == 3, k == 2 || k == 3, k == 1 || k == 2};
      @(negedge clk);
      checks++;
      if ({busy, done, out_valid} !== e) begin
        errors++;
        $display("FAIL basic k=%0d got %b want %b (busy,done,v1,v0)",
                 k, {busy, done, out_valid}, e);
      end
      step();
    end
  endtask

  task automatic test_starve();
    logic [3:0] e;
    start = 1'b1;
    row_count = 16'd2;
    step();
    start = 1'b0;
    for (int k = 0; k < 9; k++) begin
      in_valid = (k == 0 || k == 4);
      in_data = (k == 0) ? {16'h000b, 16'h000a}
                         : {16'h000d, 16'h000c};
      e = {k <= 7, k == 7, k == 3 || k == 7, k == 2 || k == 6};
      @(negedge clk);
      checks++;
      if ({busy, done, out_valid} !== e) begin
        errors++;
        $display("FAIL starve k=%0d got %b want %b",
                 k, {busy, done, out_valid}, e);
      end
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_full();
    int acc;
    logic [3:0] ec;
    acc = 0;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_data = {16'(16'h0140 + k), 16'(16'h0040 + k)};
      ec = (k < 8) ? 4'(k) : 4'd8;
      @(negedge clk);
      checks++;
      if (fifo_count !== ec || in_ready !== (k < 8)) begin
        errors++;
        $display("FAIL fill k=%0d got cnt=%0d rdy=%b want %0d/%b",
                 k, fifo_count, in_ready, ec, k < 8);
      end
      if (in_valid && in_ready) acc++;
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (acc != 8) begin
      errors++;
      $display("FAIL fill_accepted got %0d want 8", acc);
    end
    start = 1'b1;
    row_count = 16'd8;
    step();
    start = 1'b0;
    for (int k = 0; k < 11; k++) begin
      in_valid = (k <= 3);
      in_data = {16'(16'h0180 + k), 16'(16'h0080 + k)};
      if (k == 0)      ec = 4'd8;
      else if (k <= 4) ec = 4'd7;
      else if (k <= 8) ec = 4'(11 - k);
      else             ec = 4'd3;
      @(negedge clk);
      checks++;
      if (fifo_count !== ec || in_ready !== (k != 0)) begin
        errors++;
        $display("FAIL drain_cnt k=%0d got cnt=%0d rdy=%b want %0d/%b",
                 k, fifo_count, in_ready, ec, k != 0);
      end
      checks++;
      if ({busy, done} !== {k <= 9, k == 9}) begin
        errors++;
        $display("FAIL drain_fsm k=%0d got %b want %b",
                 k, {busy, done}, {k <= 9, k == 9});
      end
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_edge();
    logic [3:0] e;
    logic [3:0] ec;
    start = 1'b1;
    row_count = 16'd0;
    step();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      e = (k == 0) ? 4'b1100 : 4'b0000;
      @(negedge clk);
      checks++;
      if ({busy, done, out_valid} !== e || fifo_count !== 4'd3) begin
        errors++;
        $display("FAIL zero_rows k=%0d got %b cnt=%0d want %b cnt=3",
                 k, {busy, done, out_valid}, fifo_count, e);
      end
      step();
    end
    start = 1'b1;
    row_count = 16'd2;
    step();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      start = (k == 1);
      row_count = (k == 1) ? 16'd1 : 16'd2;
      e = {k <= 3, k == 3, k == 2 || k == 3, k == 1 || k == 2};
      ec = (k == 0) ? 4'd3 : (k == 1) ? 4'd2 : 4'd1;
      @(negedge clk);
      checks++;
      if ({busy, done, out_valid} !== e || fifo_count !== ec) begin
        errors++;
        $display("FAIL busy_start k=%0d got %b cnt=%0d want %b cnt=%0d",
                 k, {busy, done, out_valid}, fifo_count, e, ec);
      end
      step();
    end
    start = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] e;
    in_valid = 1'b1;
    for (int j = 0; j < 7; j++) begin
      in_data = {16'(16'h0300 + j), 16'(16'h0200 + j)};
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (fifo_count !== 4'd8) begin
      errors++;
      $display("FAIL b2b_fill got %0d want 8", fifo_count);
    end
    step();
    for (int k = 0; k < 22; k++) begin
      start = (k == 0 || k == 11);
      row_count = (k == 11) ? 16'd6 : 16'd8;
      in_valid = (k >= 3 && k <= 8);
      in_data = {16'(16'h0500 + k), 16'(16'h0400 + k)};
      e = {(k >= 1 && k <= 10) || (k >= 12 && k <= 19),
           k == 10 || k == 19,
           (k >= 3 && k <= 10) || (k >= 14 && k <= 19),
           (k >= 2 && k <= 9) || (k >= 13 && k <= 18)};
      @(negedge clk);
      checks++;
      if ({busy, done, out_valid} !== e) begin
        errors++;
        $display("FAIL b2b k=%0d got %b want %b",
                 k, {busy, done, out_valid}, e);
      end
      step();
    end
    start = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (fifo_count !== 4'd0) begin
      errors++;
      $display("FAIL b2b_empty got %0d want 0", fifo_count);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_starve();
    test_full();
    test_edge();
    test_back_to_back();
    repeat (3) step();
    checks++;
    if (sb0.size() != 0 || sb1.size() != 0) begin
      errors++;
      $display("FAIL sb_left got %0d/%0d entries want 0/0",
               sb0.size(), sb1.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
